line_pixel_timer: RTL and testbench
===================================

Name: line_pixel_timer

Overview:
Upstream neighbour of the 24-line frame counter. Paces the horizontal scan: steps a column index across the active pixels of a line, then through a horizontal blank. At each line end it issues a one-cycle new_line pulse to the line counter. It samples the counter's end_frame level to decide whether to start another line or park in a frame-done state until software cycles enb.

Parameters:
H_ACTIVE, 32, active pixels per line (>=1)
H_BLANK, 4, blank ticks per line (>=1)
COL_W, 6, column/blank counter width; must hold max(H_ACTIVE,H_BLANK)-1 (elaboration-time check)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
enb  input  1  block enable, active high; same signal that enables the line counter
pix_tick  input  1  pixel advance strobe; one pixel/blank step per cycle it is high
end_frame  input  1  level from line counter, high when 24 lines counted
new_line  output  1  one-cycle pulse per completed line, registered
col  output  COL_W  current active column, 0..H_ACTIVE-1, registered
pixel_valid  output  1  high while in ACTIVE (col is meaningful)
frame_done  output  1  high while in DONE

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on rst_n; all state and outputs clear immediately on rst_n=0: state=IDLE, col=0, blank count=0, new_line=0, pixel_valid=0, frame_done=0.
- All outputs are registered or decoded directly from the state register. No input-to-output combinational paths.
- States: IDLE, ACTIVE, BLANK, SYNC, CHECK, DONE.
- IDLE: col=0. On enb=1 -> ACTIVE with col=0.
- ACTIVE: pixel_valid=1. On pix_tick, col+1. On pix_tick with col==H_ACTIVE-1 -> BLANK, blank count=0, col=0.
- BLANK: on pix_tick, blank count+1. On pix_tick with blank count==H_BLANK-1 -> SYNC, new_line<=1.
- SYNC: lasts exactly 1 cycle; new_line=1 in this cycle only; -> CHECK. The line counter increments on this edge.
- CHECK: lasts exactly 1 cycle. end_frame now reflects the updated line count. If end_frame=1 -> DONE, else -> ACTIVE with col=0.
- DONE: frame_done=1, held for as long as enb=1. On enb=0 -> IDLE.
- Result: exactly 24 new_line pulses per frame.
- Line period with pix_tick tied high: H_ACTIVE+H_BLANK+2 cycles.
- pix_tick is ignored in SYNC, CHECK, DONE and IDLE.
- enb=0 in any state has priority over all other transitions: next state IDLE, counters cleared, new_line forced 0 (a pending SYNC pulse is suppressed), frame_done=0.
- end_frame is only sampled in CHECK; its value in other states is ignored.
- Counters never wrap: the terminal compare forces the state change, so col never exceeds H_ACTIVE-1.
- Async reset mid-line: next line after release restarts at col 0 once enb=1.

Decomposition:
- Package line_timer_pkg:
  - state enum (6 states, 3 bits);
  - default H_ACTIVE/H_BLANK constants;
  - LINES_PER_FRAME=24, shared with the line counter.
- One natural sub-module: mod_tick_counter, a mod-N counter with clear, advance-enable and terminal-count flag. Instantiated twice: column counter and blank counter.

Test Plan:
- rst_n pulsed low while ACTIVE at col=2 -> same-cycle col=0, pixel_valid=0, new_line=0, frame_done=0; after release with enb=1, first ACTIVE cycle shows col=0.
- H_ACTIVE=4, H_BLANK=2, pix_tick=1, enb=1 -> pixel_valid high 4 cycles with col 0,1,2,3; 2 blank cycles; new_line high exactly 1 cycle; new_line pulses exactly 8 cycles apart.
- Same config, pix_tick toggling 1,0,1,0 -> col holds on idle cycles; each value held 2 cycles; new_line still a single-cycle pulse; line period 14 cycles.
- Behavioural 24-line counter model attached (increments on new_line, end_frame at count 24) -> exactly 24 new_line pulses; DONE entered in CHECK after the 24th; frame_done=1 and pixel_valid=0 thereafter while enb=1.
- enb dropped during BLANK on the final tick (SYNC would follow) -> no new_line pulse; IDLE next cycle; re-raising enb starts ACTIVE at col=0.
- In DONE, enb low 1 cycle then high -> frame_done falls; new frame starts with col=0; 24 further new_line pulses before frame_done rises again.

Source files
------------

// File: rtl/line_pixel_timer_pkg.sv
// -----------------------------------------------------------------------------
// line_timer_pkg
// Shared definitions for the horizontal line/pixel timer and its neighbour,
// the per-frame line counter.
//   - line_state_e    : horizontal scan FSM states (3-bit encoding)
//   - DEF_H_ACTIVE    : default active pixels per line
//   - DEF_H_BLANK     : default blank ticks per line
//   - LINES_PER_FRAME : lines per frame, shared with the line counter
// -----------------------------------------------------------------------------
package line_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_BLANK  = 3'd2,
        ST_SYNC   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } line_state_e;

    localparam int DEF_H_ACTIVE    = 32;
    localparam int DEF_H_BLANK     = 4;
    localparam int LINES_PER_FRAME = 24;

endpackage : line_timer_pkg

// File: rtl/mod_tick_counter.sv
// -----------------------------------------------------------------------------
// mod_tick_counter
// Mod-N up counter with synchronous clear, advance enable and a terminal-count
// flag. Clear has priority over advance.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous reset, active low
//   i_clr   : synchronous clear to 0
//   i_adv   : advance by one (wraps N-1 -> 0)
//   o_cnt   : current count, registered
//   o_tc    : high while o_cnt == N-1 (decoded from the count register)
// -----------------------------------------------------------------------------
module mod_tick_counter #(
    parameter int N = 4,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_adv,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LAST);

endmodule : mod_tick_counter

// File: rtl/line_pixel_timer.sv
// -----------------------------------------------------------------------------
// line_pixel_timer
// Paces the horizontal scan: steps a column index across the active pixels of
// a line, then through a horizontal blank, emits a one-cycle new_line pulse to
// the line counter, and then looks at the counter's end_frame level to either
// start another line or park in DONE until enb is cycled.
//
// Handshake: there is no valid/ready flow here. pix_tick is a plain strobe
// (one step per cycle it is high, only in ACTIVE/BLANK); new_line is a
// one-cycle registered pulse the line counter must count on the same edge;
// end_frame is trusted only in CHECK, one cycle after that edge.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous reset, active low
//   enb         : block enable; low forces IDLE from any state
//   pix_tick    : pixel/blank advance strobe
//   end_frame   : level from line counter, high when the frame's lines are done
//   new_line    : one-cycle pulse per completed line, registered
//   col         : current active column 0..H_ACTIVE-1, registered
//   pixel_valid : high while in ACTIVE
//   frame_done  : high while in DONE
//   dbg_state   : FSM state register, for observation
// -----------------------------------------------------------------------------
module line_pixel_timer
    import line_timer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int COL_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             pix_tick,
    input  logic             end_frame,
    output logic             new_line,
    output logic [COL_W-1:0] col,
    output logic             pixel_valid,
    output logic             frame_done,
    output logic [2:0]       dbg_state
);

    // Both counters share COL_W, so it must hold the larger terminal value.
    if (H_ACTIVE < 1 || H_BLANK < 1 ||
        (H_ACTIVE - 1) >= (1 << COL_W) || (H_BLANK - 1) >= (1 << COL_W)) begin : g_bad_params
        $error("line_pixel_timer: H_ACTIVE/H_BLANK must be >=1 and fit in COL_W bits");
    end

    line_state_e      r_state;
    logic             r_new_line;

    logic [COL_W-1:0] w_col_cnt;
    logic             w_col_tc;
    logic             w_col_clr;
    logic             w_col_adv;
    logic [COL_W-1:0] w_blk_cnt;
    logic             w_blk_tc;
    logic             w_blk_clr;
    logic             w_blk_adv;
    logic             w_in_active;
    logic             w_in_blank;

    assign w_in_active = (r_state == ST_ACTIVE);
    assign w_in_blank  = (r_state == ST_BLANK);

    // Each counter is held at 0 outside its own state and is cleared on its
    // terminal step, so every line and every blank starts from 0 and neither
    // ever wraps through the mod-N path.
    assign w_col_clr = !enb || !w_in_active || (pix_tick && w_col_tc);
    assign w_col_adv = enb && w_in_active && pix_tick;
    assign w_blk_clr = !enb || !w_in_blank  || (pix_tick && w_blk_tc);
    assign w_blk_adv = enb && w_in_blank  && pix_tick;

    mod_tick_counter #(
        .N (H_ACTIVE),
        .W (COL_W)
    ) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_col_clr),
        .i_adv (w_col_adv),
        .o_cnt (w_col_cnt),
        .o_tc  (w_col_tc)
    );

    mod_tick_counter #(
        .N (H_BLANK),
        .W (COL_W)
    ) u_blk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_blk_clr),
        .i_adv (w_blk_adv),
        .o_cnt (w_blk_cnt),
        .o_tc  (w_blk_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_new_line <= 1'b0;
        end else if (!enb) begin
            // Disable wins over everything, including a SYNC about to be entered.
            r_state    <= ST_IDLE;
            r_new_line <= 1'b0;
        end else begin
            r_new_line <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (pix_tick && w_col_tc) begin
                        r_state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (pix_tick && w_blk_tc) begin
                        r_state    <= ST_SYNC;
                        r_new_line <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    // Line counter counts on this edge; end_frame settles for CHECK.
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_state <= end_frame ? ST_DONE : ST_ACTIVE;
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign new_line    = r_new_line;
    assign col         = w_col_cnt;
    assign pixel_valid = w_in_active;
    assign frame_done  = (r_state == ST_DONE);
    assign dbg_state   = r_state;

endmodule : line_pixel_timer

// File: tb/tb_line_pixel_timer.sv
// Directed bench for line_pixel_timer with H_ACTIVE=4, H_BLANK=2, plus a
// behavioural 24-line counter closing the new_line/end_frame loop.
module tb_line_pixel_timer;
  import line_timer_pkg::*;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int CW = 3;
  localparam int LINE_CYC  = HA + HB + 2;
  localparam int FRAME_CYC = LINES_PER_FRAME * LINE_CYC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic enb;
  logic pix_tick;
  logic end_frame;
  logic new_line;
  logic [CW-1:0] col;
  logic pixel_valid;
  logic frame_done;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  line_pixel_timer #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .COL_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enb         (enb),
    .pix_tick    (pix_tick),
    .end_frame   (end_frame),
    .new_line    (new_line),
    .col         (col),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // Behavioural line counter: counts new_line pulses, cleared while disabled.
  int line_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_cnt <= 0;
    else if (!enb) line_cnt <= 0;
    else if (new_line) line_cnt <= line_cnt + 1;
  end
  assign end_frame = (line_cnt == LINES_PER_FRAME);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Runs from the current negedge until frame_done is seen, bounded.
  task automatic run_frame(output int pulses, output int cycles, output bit timed_out);
    pulses = 0;
    cycles = 0;
    while (!frame_done && cycles < FRAME_CYC + 50) begin
      if (new_line) pulses++;
      @(negedge clk);
      cycles++;
    end
    timed_out = !frame_done;
  endtask

  // Expected per-cycle tables for one line.
  logic [CW-1:0] fast_col [LINE_CYC] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
  logic          fast_pv  [LINE_CYC] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic          fast_nl  [LINE_CYC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [CW-1:0] slow_col [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                                   3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic          slow_pv  [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic          slow_nl  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  int  pulses;
  int  cycles;
  bit  timed_out;

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    enb = 1'b0;
    pix_tick = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_col", col, 0);
    check("rst_pv", pixel_valid, 0);
    check("rst_nl", new_line, 0);
    check("rst_fd", frame_done, 0);

    // Start a line, then reset asynchronously at col=2
    rst_n = 1'b1;
    enb = 1'b1;
    pix_tick = 1'b1;
    @(negedge clk);
    check("first_pv", pixel_valid, 1);
    check("first_col", col, 0);
    @(negedge clk);
    check("col_1", col, 1);
    @(negedge clk);
    check("col_2", col, 2);
    rst_n = 1'b0;
    #1;
    check("async_col", col, 0);
    check("async_pv", pixel_valid, 0);
    check("async_nl", new_line, 0);
    check("async_fd", frame_done, 0);
    check("async_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_pv", pixel_valid, 1);
    check("rel_col", col, 0);

    // Two lines at full speed: pulses 8 cycles apart
    for (int i = 0; i < 2 * LINE_CYC; i++) begin
      check($sformatf("fast_col[%0d]", i), col, fast_col[i % LINE_CYC]);
      check($sformatf("fast_pv[%0d]", i), pixel_valid, fast_pv[i % LINE_CYC]);
      check($sformatf("fast_nl[%0d]", i), new_line, fast_nl[i % LINE_CYC]);
      @(negedge clk);
    end

    // Two lines with pix_tick toggling 0,1,0,1: period 14
    for (int i = 0; i < 28; i++) begin
      check($sformatf("slow_col[%0d]", i), col, slow_col[i % 14]);
      check($sformatf("slow_pv[%0d]", i), pixel_valid, slow_pv[i % 14]);
      check($sformatf("slow_nl[%0d]", i), new_line, slow_nl[i % 14]);
      pix_tick = logic'(i % 2);
      @(negedge clk);
    end

    // enb dropped on the final blank tick: SYNC pulse suppressed
    pix_tick = 1'b1;
    check("pre_drop_col", col, 0);
    repeat (5) @(negedge clk);
    check("drop_in_blank", dbg_state, ST_BLANK);
    enb = 1'b0;
    @(negedge clk);
    check("drop_state", dbg_state, ST_IDLE);
    check("drop_nl", new_line, 0);
    check("drop_col", col, 0);
    @(negedge clk);
    check("drop_nl_2", new_line, 0);
    enb = 1'b1;
    @(negedge clk);
    check("reen_state", dbg_state, ST_ACTIVE);
    check("reen_col", col, 0);

    // Full frame against the line counter model
    run_frame(pulses, cycles, timed_out);
    check("f1_timeout", timed_out, 0);
    check("f1_pulses", pulses, LINES_PER_FRAME);
    check("f1_cycles", cycles, FRAME_CYC);
    for (int i = 0; i < 3; i++) begin
      check("done_fd", frame_done, 1);
      check("done_pv", pixel_valid, 0);
      check("done_nl", new_line, 0);
      @(negedge clk);
    end

    // Cycle enb for one cycle in DONE: second frame
    enb = 1'b0;
    @(negedge clk);
    check("cyc_fd", frame_done, 0);
    check("cyc_state", dbg_state, ST_IDLE);
    enb = 1'b1;
    @(negedge clk);
    check("f2_col", col, 0);
    check("f2_pv", pixel_valid, 1);
    run_frame(pulses, cycles, timed_out);
    check("f2_timeout", timed_out, 0);
    check("f2_pulses", pulses, LINES_PER_FRAME);
    check("f2_cycles", cycles, FRAME_CYC);
    check("f2_fd", frame_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_line_pixel_timer
